// File: rtl/sattn_cmd_sequencer_if.sv
// rtl/sattn_cmd_sequencer_if.sv - descriptor, MMIO and response bundle for sattn_cmd_sequencer
// master = sequencer side, slave = host / accelerator side.
interface sattn_cmd_sequencer_if #(
  parameter int ADDR_WIDTH = 16
);
  logic                  cmd_valid;
  logic                  cmd_ready;
  logic [7:0]            cmd_opcode;
  logic [15:0]           cmd_m_rows;
  logic [15:0]           cmd_head_d;
  logic [15:0]           cmd_s_tokens;
  logic [15:0]           cmd_block_sz;
  logic [31:0]           cmd_scale;

  logic                  mmio_wen;
  logic                  mmio_ren;
  logic [ADDR_WIDTH-1:0] mmio_addr;
  logic [63:0]           mmio_wdata;
  logic [63:0]           mmio_rdata;
  logic                  acc_done;

  logic                  rsp_valid;
  logic                  rsp_ready;
  logic [7:0]            rsp_opcode;
  logic [63:0]           rsp_sum;
  logic [31:0]           rsp_cycles;
  logic                  rsp_timeout;

  modport master (
    input  cmd_valid, cmd_opcode, cmd_m_rows, cmd_head_d, cmd_s_tokens, cmd_block_sz, cmd_scale,
    output cmd_ready,
    output mmio_wen, mmio_ren, mmio_addr, mmio_wdata,
    input  mmio_rdata, acc_done,
    output rsp_valid, rsp_opcode, rsp_sum, rsp_cycles, rsp_timeout,
    input  rsp_ready
  );

  modport slave (
    output cmd_valid, cmd_opcode, cmd_m_rows, cmd_head_d, cmd_s_tokens, cmd_block_sz, cmd_scale,
    input  cmd_ready,
    input  mmio_wen, mmio_ren, mmio_addr, mmio_wdata,
    output mmio_rdata, acc_done,
    input  rsp_valid, rsp_opcode, rsp_sum, rsp_cycles, rsp_timeout,
    output rsp_ready
  );
endinterface

// File: rtl/sattn_cmd_sequencer.sv
// rtl/sattn_cmd_sequencer.sv - descriptor FIFO + FSM that programs, issues and collects sparse-attention commands
// Optional WAIT watchdog enabled by defining SATTN_SEQ_TIMEOUT_EN.
module sattn_cmd_sequencer #(
  parameter int DEPTH          = 4,
  parameter int ADDR_WIDTH     = 16,
  parameter int TIMEOUT_CYCLES = 4096
) (
  input  logic                   clk,
  input  logic                   rst,
  sattn_cmd_sequencer_if.master  bus,
  output logic [$clog2(DEPTH):0] fifo_level,
  output logic                   seq_busy
);
  localparam int PW = $clog2(DEPTH);
  localparam logic [PW:0] FULL_LEVEL = (PW + 1)'(DEPTH);

  localparam logic [ADDR_WIDTH-1:0] A_M_ROWS   = ADDR_WIDTH'(16'h0030);
  localparam logic [ADDR_WIDTH-1:0] A_HEAD_D   = ADDR_WIDTH'(16'h0038);
  localparam logic [ADDR_WIDTH-1:0] A_BLOCK_SZ = ADDR_WIDTH'(16'h0040);
  localparam logic [ADDR_WIDTH-1:0] A_S_TOKENS = ADDR_WIDTH'(16'h0050);
  localparam logic [ADDR_WIDTH-1:0] A_SCALE_FP = ADDR_WIDTH'(16'h0058);
  localparam logic [ADDR_WIDTH-1:0] A_CMD      = ADDR_WIDTH'(16'h0060);
  localparam logic [ADDR_WIDTH-1:0] A_ACC_SUM  = ADDR_WIDTH'(16'h0068);
  localparam logic [ADDR_WIDTH-1:0] A_SOF_SUM  = ADDR_WIDTH'(16'h0080);
  localparam logic [ADDR_WIDTH-1:0] A_SPM_SUM  = ADDR_WIDTH'(16'h0088);

`ifdef SATTN_SEQ_TIMEOUT_EN
  localparam logic [31:0] TMO = 32'(TIMEOUT_CYCLES);
`endif

  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0 || TIMEOUT_CYCLES < 1) begin : g_param_check
    $error("sattn_cmd_sequencer: DEPTH must be a power of two >= 2 and TIMEOUT_CYCLES >= 1");
  end

  typedef struct packed {
    logic [7:0]  opcode;
    logic [15:0] m_rows;
    logic [15:0] head_d;
    logic [15:0] s_tokens;
    logic [15:0] block_sz;
    logic [31:0] scale;
  } desc_t;

  typedef enum logic [2:0] {IDLE, CFG, ISSUE, WAIT, READ, RESP} state_t;

  desc_t       mem [DEPTH];
  desc_t       in_desc;
  desc_t       head;
  logic [PW:0] wr_ptr;
  logic [PW:0] rd_ptr;
  logic        full;
  logic        empty;
  logic        live;
  logic        push;
  logic        pop;

  state_t      state;
  logic [2:0]  cfg_idx;
  logic [7:0]  work_op;
  logic [15:0] work_head_d;
  logic [15:0] work_s_tokens;
  logic [15:0] work_block_sz;
  logic [31:0] work_scale;
  logic [31:0] count;
  logic [31:0] cnt_inc;
  logic        timeout_q;
  logic        sum_op;
  logic [ADDR_WIDTH-1:0] sum_addr;

  assign in_desc = '{opcode: bus.cmd_opcode, m_rows: bus.cmd_m_rows, head_d: bus.cmd_head_d,
                     s_tokens: bus.cmd_s_tokens, block_sz: bus.cmd_block_sz, scale: bus.cmd_scale};
  assign head       = mem[rd_ptr[PW-1:0]];
  assign fifo_level = wr_ptr - rd_ptr;
  assign full       = (fifo_level == FULL_LEVEL);
  assign empty      = (fifo_level == '0);
  // live keeps cmd_ready low through reset and for the edge that releases it
  assign bus.cmd_ready = live && !full;
  assign push       = bus.cmd_valid && bus.cmd_ready;
  assign pop        = (state == IDLE) && !empty;
  assign seq_busy   = (state != IDLE);
  assign cnt_inc    = (count == 32'hFFFF_FFFF) ? count : count + 32'd1;
  assign sum_op     = work_op inside {8'h14, 8'h15, 8'h16};
  assign sum_addr   = (work_op == 8'h14) ? A_ACC_SUM :
                      (work_op == 8'h15) ? A_SOF_SUM : A_SPM_SUM;
  assign bus.rsp_timeout = timeout_q;

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr[PW-1:0]] <= in_desc;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      live   <= 1'b0;
    end else begin
      live <= 1'b1;
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state          <= IDLE;
      cfg_idx        <= '0;
      work_op        <= '0;
      work_head_d    <= '0;
      work_s_tokens  <= '0;
      work_block_sz  <= '0;
      work_scale     <= '0;
      count          <= '0;
      timeout_q      <= 1'b0;
      bus.mmio_wen   <= 1'b0;
      bus.mmio_ren   <= 1'b0;
      bus.mmio_addr  <= '0;
      bus.mmio_wdata <= '0;
      bus.rsp_valid  <= 1'b0;
      bus.rsp_opcode <= '0;
      bus.rsp_sum    <= '0;
      bus.rsp_cycles <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (!empty) begin
            work_op       <= head.opcode;
            work_head_d   <= head.head_d;
            work_s_tokens <= head.s_tokens;
            work_block_sz <= head.block_sz;
            work_scale    <= head.scale;
            if (head.opcode == 8'h00) begin
              state          <= RESP;
              bus.rsp_valid  <= 1'b1;
              bus.rsp_opcode <= 8'h00;
              bus.rsp_sum    <= '0;
              bus.rsp_cycles <= '0;
              timeout_q      <= 1'b0;
            end else begin
              // first register write goes out on the pop edge itself
              state          <= CFG;
              cfg_idx        <= 3'd1;
              bus.mmio_wen   <= 1'b1;
              bus.mmio_addr  <= A_M_ROWS;
              bus.mmio_wdata <= {48'b0, head.m_rows};
            end
          end
        end
        CFG: begin
          cfg_idx <= cfg_idx + 3'd1;
          case (cfg_idx)
            3'd1: begin
              bus.mmio_addr  <= A_HEAD_D;
              bus.mmio_wdata <= {48'b0, work_head_d};
            end
            3'd2: begin
              bus.mmio_addr  <= A_BLOCK_SZ;
              bus.mmio_wdata <= {48'b0, work_block_sz};
            end
            3'd3: begin
              bus.mmio_addr  <= A_S_TOKENS;
              bus.mmio_wdata <= {48'b0, work_s_tokens};
            end
            3'd4: begin
              bus.mmio_addr  <= A_SCALE_FP;
              bus.mmio_wdata <= {32'b0, work_scale};
            end
            default: begin
              state          <= ISSUE;
              bus.mmio_addr  <= A_CMD;
              bus.mmio_wdata <= {56'b0, work_op};
            end
          endcase
        end
        ISSUE: begin
          state          <= WAIT;
          count          <= '0;
          bus.mmio_wen   <= 1'b0;
          bus.mmio_addr  <= '0;
          bus.mmio_wdata <= '0;
        end
        WAIT: begin
          if (bus.acc_done) begin
            count <= cnt_inc;
            if (sum_op) begin
              state         <= READ;
              bus.mmio_ren  <= 1'b1;
              bus.mmio_addr <= sum_addr;
            end else begin
              state          <= RESP;
              bus.rsp_valid  <= 1'b1;
              bus.rsp_opcode <= work_op;
              bus.rsp_sum    <= '0;
              bus.rsp_cycles <= cnt_inc;
              timeout_q      <= 1'b0;
            end
          end
`ifdef SATTN_SEQ_TIMEOUT_EN
          else if (cnt_inc == TMO) begin
            state          <= RESP;
            count          <= cnt_inc;
            bus.rsp_valid  <= 1'b1;
            bus.rsp_opcode <= work_op;
            bus.rsp_sum    <= '0;
            bus.rsp_cycles <= TMO;
            timeout_q      <= 1'b1;
          end
`endif
          else begin
            count <= cnt_inc;
          end
        end
        READ: begin
          state          <= RESP;
          bus.mmio_ren   <= 1'b0;
          bus.mmio_addr  <= '0;
          bus.rsp_valid  <= 1'b1;
          bus.rsp_opcode <= work_op;
          bus.rsp_sum    <= bus.mmio_rdata;
          bus.rsp_cycles <= count;
          timeout_q      <= 1'b0;
        end
        RESP: begin
          if (bus.rsp_ready) begin
            state         <= IDLE;
            bus.rsp_valid <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_sattn_cmd_sequencer.sv
// tb/tb_sattn_cmd_sequencer.sv - scoreboard bench for sattn_cmd_sequencer
// Expected MMIO traffic and responses are queued at stimulus time and popped by independent monitors.
module tb_sattn_cmd_sequencer;
  localparam logic [63:0] RD_BASE = 64'h5A5A_0000_1234_0000;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [2:0] fifo_level;
  logic       seq_busy;
  logic       drv_done = 1'b0;
  logic       spur_done = 1'b0;

  always #5 clk = ~clk;

  sattn_cmd_sequencer_if #(.ADDR_WIDTH(16)) bus ();

  sattn_cmd_sequencer #(.DEPTH(4), .ADDR_WIDTH(16), .TIMEOUT_CYCLES(16)) dut (
    .clk(clk), .rst(rst), .bus(bus), .fifo_level(fifo_level), .seq_busy(seq_busy)
  );

  assign bus.mmio_rdata = RD_BASE | {48'b0, bus.mmio_addr};
  assign bus.acc_done   = drv_done | spur_done;

  typedef struct {
    logic [7:0]  op;
    logic [63:0] sum;
    logic [31:0] cyc;
    logic        tmo;
  } rsp_t;

  typedef struct {
    logic        wr;
    logic [15:0] addr;
    logic [63:0] data;
  } mm_t;

  rsp_t rsp_q[$];
  mm_t  mm_q[$];
  int   dly_q[$];
  int   checks = 0;
  int   errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic fail_now(input string name);
    checks++;
    errors++;
    $display("FAIL %s t=%0t", name, $time);
  endtask

  // delay < 0 means the accelerator never signals done
  task automatic send(input logic [7:0] op, input logic [15:0] m, input logic [15:0] h,
                      input logic [15:0] s, input logic [15:0] b, input logic [31:0] sc,
                      input int delay, input logic [15:0] rd_addr,
                      input logic [63:0] exp_sum, input logic [31:0] exp_cyc, input logic exp_tmo);
    bit ok;
    if (op != 8'h00) begin
      mm_q.push_back('{1'b1, 16'h0030, {48'b0, m}});
      mm_q.push_back('{1'b1, 16'h0038, {48'b0, h}});
      mm_q.push_back('{1'b1, 16'h0040, {48'b0, b}});
      mm_q.push_back('{1'b1, 16'h0050, {48'b0, s}});
      mm_q.push_back('{1'b1, 16'h0058, {32'b0, sc}});
      mm_q.push_back('{1'b1, 16'h0060, {56'b0, op}});
      if (rd_addr != 16'h0) mm_q.push_back('{1'b0, rd_addr, 64'h0});
      dly_q.push_back(delay);
    end
    rsp_q.push_back('{op, exp_sum, exp_cyc, exp_tmo});
    bus.cmd_valid    = 1'b1;
    bus.cmd_opcode   = op;
    bus.cmd_m_rows   = m;
    bus.cmd_head_d   = h;
    bus.cmd_s_tokens = s;
    bus.cmd_block_sz = b;
    bus.cmd_scale    = sc;
    ok = 1'b0;
    for (int i = 0; i < 500; i++) begin
      @(negedge clk);
      if (bus.cmd_ready) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) fail_now("push_timeout");
    @(posedge clk);
    #1 bus.cmd_valid = 1'b0;
  endtask

  task automatic drain();
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 2000; i++) begin
      @(negedge clk);
      if (rsp_q.size() == 0 && mm_q.size() == 0 && !seq_busy && fifo_level == 3'd0) begin
        ok = 1'b1;
        break;
      end
    end
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL drain_timeout rsp_pending=%0d mmio_pending=%0d", rsp_q.size(), mm_q.size());
    end
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    if (bus.mmio_wen || bus.mmio_ren) begin
      if (mm_q.size() == 0) begin
        fail_now("mmio_unexpected");
      end else begin
        mm_t e;
        e = mm_q.pop_front();
        check("mmio_kind", {62'b0, bus.mmio_wen, bus.mmio_ren}, e.wr ? 64'd2 : 64'd1);
        check("mmio_addr", {48'b0, bus.mmio_addr}, {48'b0, e.addr});
        if (e.wr) check("mmio_wdata", bus.mmio_wdata, e.data);
      end
    end else begin
      check("mmio_addr_idle", {48'b0, bus.mmio_addr}, 64'h0);
    end
  end

  always @(negedge clk) begin
    if (bus.rsp_valid) begin
      if (rsp_q.size() == 0) begin
        fail_now("rsp_unexpected");
      end else begin
        rsp_t e;
        e = rsp_q[0];
        check("rsp_opcode", {56'b0, bus.rsp_opcode}, {56'b0, e.op});
        check("rsp_sum", bus.rsp_sum, e.sum);
        check("rsp_cycles", {32'b0, bus.rsp_cycles}, {32'b0, e.cyc});
        check("rsp_timeout", {63'b0, bus.rsp_timeout}, {63'b0, e.tmo});
        if (bus.rsp_ready) void'(rsp_q.pop_front());
      end
    end
  end

  // Accelerator model: done pulse lands `delay` cycles after the ISSUE cycle
  initial begin
    forever begin
      @(negedge clk);
      if (!rst && bus.mmio_wen && bus.mmio_addr == 16'h0060) begin
        int d;
        d = (dly_q.size() != 0) ? dly_q.pop_front() : -1;
        if (d > 0) begin
          repeat (d) @(posedge clk);
          #1 drv_done = 1'b1;
          @(posedge clk);
          #1 drv_done = 1'b0;
        end
      end
    end
  end

  initial begin
    bit seen;
    bus.cmd_valid    = 1'b0;
    bus.cmd_opcode   = '0;
    bus.cmd_m_rows   = '0;
    bus.cmd_head_d   = '0;
    bus.cmd_s_tokens = '0;
    bus.cmd_block_sz = '0;
    bus.cmd_scale    = '0;
    bus.rsp_ready    = 1'b1;

    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_cmd_ready", {63'b0, bus.cmd_ready}, 64'd0);
    check("rst_rsp_valid", {63'b0, bus.rsp_valid}, 64'd0);
    check("rst_mmio_wen", {63'b0, bus.mmio_wen}, 64'd0);
    check("rst_fifo_level", {61'b0, fifo_level}, 64'd0);
    check("rst_seq_busy", {63'b0, seq_busy}, 64'd0);
    check("rst_rsp_sum", bus.rsp_sum, 64'd0);
    rst = 1'b0;
    #1 check("cmd_ready_before_edge", {63'b0, bus.cmd_ready}, 64'd0);
    @(posedge clk);
    #1 check("cmd_ready_after_edge", {63'b0, bus.cmd_ready}, 64'd1);

    // Checksum op with a 20-cycle accelerator
    send(8'h14, 16'd2, 16'd4, 16'd8, 16'd4, 32'h3F80_0000, 20, 16'h0068,
         64'h5A5A_0000_1234_0068, 32'd20, 1'b0);
    drain();

    // NOP: no MMIO, response two cycles after the push is presented
    send(8'h00, 16'd1, 16'd1, 16'd1, 16'd1, 32'h0, 0, 16'h0, 64'h0, 32'd0, 1'b0);
    @(negedge clk);
    check("nop_rsp_valid_c1", {63'b0, bus.rsp_valid}, 64'd0);
    @(negedge clk);
    check("nop_rsp_valid_c2", {63'b0, bus.rsp_valid}, 64'd1);
    drain();

    send(8'h15, 16'h0010, 16'h0020, 16'h0030, 16'h0008, 32'h4000_0000, 3, 16'h0080,
         64'h5A5A_0000_1234_0080, 32'd3, 1'b0);
    send(8'h16, 16'hFFFF, 16'h0001, 16'h8000, 16'h0002, 32'hBF80_0000, 1, 16'h0088,
         64'h5A5A_0000_1234_0088, 32'd1, 1'b0);
    send(8'h22, 16'h0005, 16'h0006, 16'h0007, 16'h0009, 32'h1234_5678, 5, 16'h0,
         64'h0, 32'd5, 1'b0);
    drain();

    // acc_done outside WAIT must be ignored
    spur_done = 1'b1;
    @(posedge clk);
    #1 spur_done = 1'b0;
    repeat (5) @(posedge clk);
    #1 check("spurious_done_idle", {63'b0, seq_busy}, 64'd0);

    // Fill the FIFO while the first descriptor stalls in WAIT
    send(8'h22, 16'd1, 16'd2, 16'd3, 16'd4, 32'h1, 40, 16'h0, 64'h0, 32'd40, 1'b0);
    send(8'h14, 16'd9, 16'd8, 16'd7, 16'd6, 32'h2, 2, 16'h0068, 64'h5A5A_0000_1234_0068, 32'd2, 1'b0);
    send(8'h15, 16'd5, 16'd4, 16'd3, 16'd2, 32'h3, 4, 16'h0080, 64'h5A5A_0000_1234_0080, 32'd4, 1'b0);
    send(8'h00, 16'd0, 16'd0, 16'd0, 16'd0, 32'h0, 0, 16'h0, 64'h0, 32'd0, 1'b0);
    send(8'h16, 16'd1, 16'd1, 16'd1, 16'd1, 32'h4, 6, 16'h0088, 64'h5A5A_0000_1234_0088, 32'd6, 1'b0);
    @(negedge clk);
    check("full_fifo_level", {61'b0, fifo_level}, 64'd4);
    check("full_cmd_ready", {63'b0, bus.cmd_ready}, 64'd0);
    check("full_seq_busy", {63'b0, seq_busy}, 64'd1);
    drain();

    // Backpressure on the response: fields hold, queued descriptor is not popped
    bus.rsp_ready = 1'b0;
    send(8'h15, 16'd3, 16'd3, 16'd3, 16'd3, 32'h5, 7, 16'h0080, 64'h5A5A_0000_1234_0080, 32'd7, 1'b0);
    seen = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (bus.rsp_valid) begin
        seen = 1'b1;
        break;
      end
    end
    if (!seen) fail_now("hold_rsp_timeout");
    @(posedge clk);
    #1;
    send(8'h00, 16'd0, 16'd0, 16'd0, 16'd0, 32'h0, 0, 16'h0, 64'h0, 32'd0, 1'b0);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("hold_fifo_level", {61'b0, fifo_level}, 64'd1);
      check("hold_rsp_valid", {63'b0, bus.rsp_valid}, 64'd1);
    end
    @(posedge clk);
    #1 bus.rsp_ready = 1'b1;
    drain();

    // Reset during the third CFG write abandons everything
    send(8'h14, 16'd2, 16'd4, 16'd8, 16'd4, 32'h3F80_0000, 10, 16'h0068,
         64'h5A5A_0000_1234_0068, 32'd10, 1'b0);
    send(8'h16, 16'd1, 16'd1, 16'd1, 16'd1, 32'h1, 3, 16'h0088,
         64'h5A5A_0000_1234_0088, 32'd3, 1'b0);
    seen = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (bus.mmio_wen && bus.mmio_addr == 16'h0040) begin
        seen = 1'b1;
        break;
      end
    end
    if (!seen) fail_now("cfg3_not_seen");
    #2 rst = 1'b1;
    mm_q.delete();
    rsp_q.delete();
    dly_q.delete();
    #1;
    check("midrst_mmio_wen", {63'b0, bus.mmio_wen}, 64'd0);
    check("midrst_fifo_level", {61'b0, fifo_level}, 64'd0);
    check("midrst_seq_busy", {63'b0, seq_busy}, 64'd0);
    check("midrst_cmd_ready", {63'b0, bus.cmd_ready}, 64'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (30) @(posedge clk);
    #1;
    check("post_rst_rsp_valid", {63'b0, bus.rsp_valid}, 64'd0);
    check("post_rst_seq_busy", {63'b0, seq_busy}, 64'd0);

`ifdef SATTN_SEQ_TIMEOUT_EN
    send(8'h14, 16'd2, 16'd4, 16'd8, 16'd4, 32'h3F80_0000, -1, 16'h0, 64'h0, 32'd16, 1'b1);
    drain();
`endif

    // Post-reset sanity: sequencer still works
    send(8'h16, 16'd7, 16'd7, 16'd7, 16'd7, 32'h7, 4, 16'h0088, 64'h5A5A_0000_1234_0088, 32'd4, 1'b0);
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
